// File: rtl/mac_se_video_scanner.sv
// Mac SE internal-CRT video scanner.
// Reads the 1-bit frame buffer in raster order and produces the serial pixel
// stream plus hsync_n/vsync_n with a fixed three-cycle counter-to-output latency.
module mac_se_video_scanner #(
    parameter int BUFFER_WIDTH  = 512,
    parameter int BUFFER_HEIGHT = 342,
    parameter int ADDR_WIDTH    = 18,
    parameter int H_TOTAL       = 704,
    parameter int V_TOTAL       = 370,
    parameter int HS_START      = 528,
    parameter int HS_END        = 704,
    parameter int VS_START      = 342,
    parameter int VS_END        = 346,
    parameter int INVERT        = 0
) (
    input  logic                  read_clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  read_enable,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_data,
    output logic                  video_out,
    output logic                  hsync_n,
    output logic                  vsync_n,
    output logic                  frame_start,
    output logic                  busy
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // One extra bit so that an end bound equal to the total never truncates.
    localparam logic [HW:0] H_ACT = (HW + 1)'(BUFFER_WIDTH);
    localparam logic [HW:0] HS_LO = (HW + 1)'(HS_START);
    localparam logic [HW:0] HS_HI = (HW + 1)'(HS_END);
    localparam logic [VW:0] V_ACT = (VW + 1)'(BUFFER_HEIGHT);
    localparam logic [VW:0] VS_LO = (VW + 1)'(VS_START);
    localparam logic [VW:0] VS_HI = (VW + 1)'(VS_END);

    localparam logic INV = (INVERT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   running;

    logic [HW-1:0]         h_count;
    logic [VW-1:0]         v_count;
    logic [ADDR_WIDTH-1:0] addr_ctr;

    logic line_wrap;
    logic frame_wrap;

    logic vld_p0, hs_p0, vs_p0, fs_p0;
    logic vld_p1, hs_p1, vs_p1, fs_p1;
    logic vld_p2, hs_p2, vs_p2, fs_p2;

    assign line_wrap  = (h_count == H_LAST);
    assign frame_wrap = line_wrap && (v_count == V_LAST);

    // Counter-stage decode; everything is forced inactive while idle so the
    // delay lines drain to reset values on their own.
    assign vld_p0 = running && ({1'b0, h_count} < H_ACT) && ({1'b0, v_count} < V_ACT);
    assign hs_p0  = running && ({1'b0, h_count} >= HS_LO) && ({1'b0, h_count} < HS_HI);
    assign vs_p0  = running && ({1'b0, v_count} >= VS_LO) && ({1'b0, v_count} < VS_HI);
    assign fs_p0  = running && (h_count == '0) && (v_count == '0);

    // State register
    always_ff @(posedge read_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a stop request only takes effect at the frame wrap
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN:   if (frame_wrap) state_nxt = enable ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        running = (state != IDLE);
        busy    = running;
    end

    // Raster counters and linear read address (no multiplier: +1 per active pixel)
    always_ff @(posedge read_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_count  <= '0;
            v_count  <= '0;
            addr_ctr <= '0;
        end else if (!running) begin
            h_count  <= '0;
            v_count  <= '0;
            addr_ctr <= '0;
        end else begin
            h_count <= line_wrap ? '0 : h_count + 1'b1;
            if (line_wrap) begin
                v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
            end
            if (frame_wrap) begin
                addr_ctr <= '0;
            end else if (vld_p0) begin
                addr_ctr <= addr_ctr + 1'b1;
            end
        end
    end

    // ---- stage p0 -> p1: registered read request ----
    always_ff @(posedge read_clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            hs_p1     <= 1'b0;
            vs_p1     <= 1'b0;
            fs_p1     <= 1'b0;
            read_addr <= '0;
        end else begin
            vld_p1 <= vld_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            fs_p1  <= fs_p0;
            if (vld_p0) begin
                read_addr <= addr_ctr;
            end
        end
    end

    assign read_enable = vld_p1;

    // ---- stage p1 -> p2: wait for frame-buffer read latency ----
    always_ff @(posedge read_clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2 <= 1'b0;
            hs_p2  <= 1'b0;
            vs_p2  <= 1'b0;
            fs_p2  <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            fs_p2  <= fs_p1;
        end
    end

    // ---- stage p2 -> output: pixel and syncs leave aligned ----
    always_ff @(posedge read_clk or negedge reset_n) begin
        if (!reset_n) begin
            video_out   <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            video_out   <= vld_p2 ? (read_data ^ INV) : 1'b0;
            hsync_n     <= ~hs_p2;
            vsync_n     <= ~vs_p2;
            frame_start <= fs_p2;
        end
    end

endmodule

// File: tb/tb_mac_se_video_scanner.sv
// Bench for mac_se_video_scanner on a reduced raster so whole frames stay short.
// A position-based reference model predicts every output cycle by cycle.
module tb_mac_se_video_scanner;

    localparam int BW    = 16;
    localparam int BH    = 6;
    localparam int AW    = 8;
    localparam int HT    = 24;
    localparam int VT    = 9;
    localparam int HSS   = 18;
    localparam int HSE   = 24;
    localparam int VSS   = 6;
    localparam int VSE   = 8;
    localparam int FRAME = HT * VT;

    localparam logic [AW+5:0] RST_VAL = {1'b0, {AW{1'b0}}, 5'b01100};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n  = 1'b0;
    logic enable = 1'b0;

    logic          re0, re1, vid0, vid1, hs0, hs1, vs0, vs1, fs0, fs1, bz0, bz1;
    logic [AW-1:0] ra0, ra1;
    logic          rd0 = 1'b0;
    logic          rd1;

    bit mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural frame buffers: one-cycle read latency; the inverted unit sees all zeros.
    always @(posedge clk) rd0 <= mem[ra0];
    assign rd1 = 1'b0;

    mac_se_video_scanner #(
        .BUFFER_WIDTH(BW), .BUFFER_HEIGHT(BH), .ADDR_WIDTH(AW), .H_TOTAL(HT), .V_TOTAL(VT),
        .HS_START(HSS), .HS_END(HSE), .VS_START(VSS), .VS_END(VSE), .INVERT(0)
    ) dut (
        .read_clk(clk), .reset_n(rst_n), .enable(enable), .read_enable(re0), .read_addr(ra0),
        .read_data(rd0), .video_out(vid0), .hsync_n(hs0), .vsync_n(vs0),
        .frame_start(fs0), .busy(bz0)
    );

    mac_se_video_scanner #(
        .BUFFER_WIDTH(BW), .BUFFER_HEIGHT(BH), .ADDR_WIDTH(AW), .H_TOTAL(HT), .V_TOTAL(VT),
        .HS_START(HSS), .HS_END(HSE), .VS_START(VSS), .VS_END(VSE), .INVERT(1)
    ) dut_inv (
        .read_clk(clk), .reset_n(rst_n), .enable(enable), .read_enable(re1), .read_addr(ra1),
        .read_data(rd1), .video_out(vid1), .hsync_n(hs1), .vsync_n(vs1),
        .frame_start(fs1), .busy(bz1)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit scan;
        int p;
    } src_t;

    src_t d1 = '{0, 0};
    src_t d2 = '{0, 0};
    src_t d3 = '{0, 0};
    src_t cur;
    bit   m_scan = 0;
    bit   m_stop = 0;
    int   m_p    = 0;

    logic          exp_re = 0, exp_vid = 0, exp_vid_inv = 0, exp_hs = 1, exp_vs = 1;
    logic          exp_fs = 0, exp_busy = 0;
    logic [AW-1:0] exp_ra = '0;

    function automatic bit f_act(src_t s);
        return s.scan && ((s.p % HT) < BW) && ((s.p / HT) < BH);
    endfunction

    function automatic int f_addr(src_t s);
        return (s.p / HT) * BW + (s.p % HT);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_scan = 0; m_stop = 0; m_p = 0;
                d1 = '{0, 0}; d2 = '{0, 0}; d3 = '{0, 0};
                exp_re = 0; exp_ra = '0; exp_vid = 0; exp_vid_inv = 0;
                exp_hs = 1; exp_vs = 1; exp_fs = 0; exp_busy = 0;
            end else begin
                cur.scan = m_scan;
                cur.p    = m_p;
                d3 = d2; d2 = d1; d1 = cur;
                if (!m_scan) begin
                    if (enable) begin m_scan = 1; m_stop = 0; m_p = 0; end
                end else begin
                    if (m_p == FRAME - 1 && m_stop) begin
                        if (enable) m_stop = 0;
                        else m_scan = 0;
                    end else if (!m_stop && !enable) begin
                        m_stop = 1;
                    end
                    m_p = (m_p + 1) % FRAME;
                end
                exp_re = f_act(d1);
                if (exp_re) exp_ra = AW'(f_addr(d1));
                exp_vid     = f_act(d3) ? mem[f_addr(d3)] : 1'b0;
                exp_vid_inv = f_act(d3);
                exp_hs   = !(d3.scan && (d3.p % HT) >= HSS && (d3.p % HT) < HSE);
                exp_vs   = !(d3.scan && (d3.p / HT) >= VSS && (d3.p / HT) < VSE);
                exp_fs   = d3.scan && (d3.p == 0);
                exp_busy = m_scan;
            end
        end
    end

    logic [AW+5:0] obs0, obs1, exp0, exp1;
    assign obs0 = {re0, ra0, vid0, hs0, vs0, fs0, bz0};
    assign obs1 = {re1, ra1, vid1, hs1, vs1, fs1, bz1};
    assign exp0 = {exp_re, exp_ra, exp_vid, exp_hs, exp_vs, exp_fs, exp_busy};
    assign exp1 = {exp_re, exp_ra, exp_vid_inv, exp_hs, exp_vs, exp_fs, exp_busy};

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < (1 << AW); i++) mem[i] = rnd ? 1'($urandom) : 1'(i & 1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (obs0 !== RST_VAL) begin bad++; $display("FAIL reset_norm got=%h exp=%h", obs0, RST_VAL); end
        total++; if (obs1 !== RST_VAL) begin bad++; $display("FAIL reset_inv got=%h exp=%h", obs1, RST_VAL); end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (obs0 !== exp0) begin bad++; $display("FAIL idle_hold cyc=%0d got=%h exp=%h", cyc, obs0, exp0); end
        end
    endtask

    task automatic test_first_frame();
        int first_re = -1, first_fs = -1;
        logic [AW-1:0] first_ra = '1;
        enable = 1'b1;
        for (int k = 0; k < FRAME + 6; k++) begin
            @(negedge clk);
            total++; if (obs0 !== exp0) begin bad++; $display("FAIL first_frame cyc=%0d got=%h exp=%h", cyc, obs0, exp0); end
            total++; if (obs1 !== exp1) begin bad++; $display("FAIL first_frame_inv cyc=%0d got=%h exp=%h", cyc, obs1, exp1); end
            if (re0 && first_re < 0) begin first_re = k; first_ra = ra0; end
            if (fs0 && first_fs < 0) first_fs = k;
            if (k >= 3 && k < 3 + HT) begin
                total++;
                if (vid0 !== ((k - 3) < BW ? 1'((k - 3) & 1) : 1'b0)) begin
                    bad++; $display("FAIL line0_pattern k=%0d got=%b", k, vid0);
                end
            end
        end
        total++; if (first_re != 1) begin bad++; $display("FAIL first_read got=%0d exp=1", first_re); end
        total++; if (first_ra !== '0) begin bad++; $display("FAIL first_addr got=%0d exp=0", first_ra); end
        total++; if (first_fs != 3) begin bad++; $display("FAIL first_fs got=%0d exp=3", first_fs); end
    endtask

    task automatic test_line_frame();
        localparam int N = 2 * FRAME + HT;
        logic re_h [0:N-1];
        logic hs_h [0:N-1];
        logic vs_h [0:N-1];
        logic [AW-1:0] ra_h [0:N-1];
        int fs_k[$];
        int hs_low = 0, vs_low = 0, max_ra = 0, f0, hs_fall = -1, vs_fall = -1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            total++; if (obs0 !== exp0) begin bad++; $display("FAIL line_frame cyc=%0d got=%h exp=%h", cyc, obs0, exp0); end
            re_h[k] = re0; ra_h[k] = ra0; hs_h[k] = hs0; vs_h[k] = vs0;
            if (fs0) fs_k.push_back(k);
            if (re0 && int'(ra0) > max_ra) max_ra = int'(ra0);
        end
        total++; if (fs_k.size() < 2) begin bad++; $display("FAIL fs_count got=%0d exp>=2", fs_k.size()); end
        else begin
            f0 = fs_k[0];
            total++; if (fs_k[1] - f0 != FRAME) begin bad++; $display("FAIL fs_period got=%0d exp=%0d", fs_k[1] - f0, FRAME); end
            for (int k = f0; k < f0 + FRAME; k++) begin
                if (!hs_h[k]) hs_low++;
                if (!vs_h[k]) vs_low++;
                if (k > f0 && hs_h[k-1] && !hs_h[k] && hs_fall < 0) hs_fall = k - f0;
                if (k > f0 && vs_h[k-1] && !vs_h[k] && vs_fall < 0) vs_fall = k - f0;
            end
            total++; if (hs_low != VT * (HSE - HSS)) begin bad++; $display("FAIL hs_low got=%0d exp=%0d", hs_low, VT * (HSE - HSS)); end
            total++; if (vs_low != (VSE - VSS) * HT) begin bad++; $display("FAIL vs_low got=%0d exp=%0d", vs_low, (VSE - VSS) * HT); end
            total++; if (hs_fall != HSS) begin bad++; $display("FAIL hs_start got=%0d exp=%0d", hs_fall, HSS); end
            total++; if (vs_fall != VSS * HT) begin bad++; $display("FAIL vs_start got=%0d exp=%0d", vs_fall, VSS * HT); end
            total++; if (re_h[f0-2+HT] !== 1'b1 || ra_h[f0-2+HT] !== AW'(BW)) begin
                bad++; $display("FAIL line1_addr got=%0d exp=%0d", ra_h[f0-2+HT], BW);
            end
            total++; if (ra_h[f0-3+FRAME] !== AW'(BW * BH - 1)) begin
                bad++; $display("FAIL last_addr got=%0d exp=%0d", ra_h[f0-3+FRAME], BW * BH - 1);
            end
            total++; if (re_h[f0-2+FRAME] !== 1'b1 || ra_h[f0-2+FRAME] !== '0) begin
                bad++; $display("FAIL addr_wrap got=%0d exp=0", ra_h[f0-2+FRAME]);
            end
        end
        total++; if (max_ra != BW * BH - 1) begin bad++; $display("FAIL max_addr got=%0d exp=%0d", max_ra, BW * BH - 1); end
    endtask

    task automatic test_invert();
        int ones = 0, hs_low = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            total++; if (obs1 !== exp1) begin bad++; $display("FAIL invert cyc=%0d got=%h exp=%h", cyc, obs1, exp1); end
            if (vid1) ones++;
            if (!hs1) hs_low++;
        end
        total++; if (ones != BW * BH) begin bad++; $display("FAIL inv_ones got=%0d exp=%0d", ones, BW * BH); end
        total++; if (hs_low != VT * (HSE - HSS)) begin bad++; $display("FAIL inv_hs_low got=%0d exp=%0d", hs_low, VT * (HSE - HSS)); end
    endtask

    task automatic test_drain();
        int n, busy_low = 0, fall_k = -1;
        n = 0; while (!(m_scan && m_p == 2 * HT) && n < 2 * FRAME) begin @(negedge clk); n++; end
        total++; if (n >= 2 * FRAME) begin bad++; $display("FAIL drain_wait1 got=timeout exp=line2"); end
        enable = 1'b0;
        n = 0; while (!(m_p == 5 * HT) && n < 2 * FRAME) begin
            @(negedge clk); n++;
            total++; if (obs0 !== exp0) begin bad++; $display("FAIL drain_a cyc=%0d got=%h exp=%h", cyc, obs0, exp0); end
        end
        enable = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            total++; if (obs0 !== exp0) begin bad++; $display("FAIL drain_b cyc=%0d got=%h exp=%h", cyc, obs0, exp0); end
            if (!bz0) busy_low++;
        end
        total++; if (busy_low != 0) begin bad++; $display("FAIL drain_busy got=%0d exp=0", busy_low); end
        n = 0; while (!(m_scan && m_p == 2 * HT) && n < 2 * FRAME) begin @(negedge clk); n++; end
        total++; if (n >= 2 * FRAME) begin bad++; $display("FAIL drain_wait2 got=timeout exp=line2"); end
        enable = 1'b0;
        for (int k = 0; k < FRAME + 5; k++) begin
            @(negedge clk);
            total++; if (obs0 !== exp0) begin bad++; $display("FAIL drain_c cyc=%0d got=%h exp=%h", cyc, obs0, exp0); end
            if (!bz0 && fall_k < 0) fall_k = k;
            if (k == FRAME - 2 * HT + 2) begin
                total++;
                if ({bz0, hs0, vs0, re0, vid0} !== 5'b01100) begin
                    bad++; $display("FAIL drain_settle got=%b exp=01100", {bz0, hs0, vs0, re0, vid0});
                end
            end
        end
        total++; if (fall_k != FRAME - 2 * HT - 1) begin bad++; $display("FAIL busy_fall got=%0d exp=%0d", fall_k, FRAME - 2 * HT - 1); end
    endtask

    task automatic test_reset_midline();
        int n, first_re = -1, first_fs = -1;
        logic [AW-1:0] first_ra = '1;
        enable = 1'b1;
        n = 0; while (!(m_scan && m_p == 3 * HT + 10) && n < 2 * FRAME) begin @(negedge clk); n++; end
        total++; if (n >= 2 * FRAME) begin bad++; $display("FAIL midline_wait got=timeout exp=h10v3"); end
        rst_n = 1'b0;
        #1;
        total++; if (obs0 !== RST_VAL) begin bad++; $display("FAIL async_reset got=%h exp=%h", obs0, RST_VAL); end
        total++; if (obs1 !== RST_VAL) begin bad++; $display("FAIL async_reset_inv got=%h exp=%h", obs1, RST_VAL); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            total++; if (obs0 !== exp0) begin bad++; $display("FAIL restart cyc=%0d got=%h exp=%h", cyc, obs0, exp0); end
            if (re0 && first_re < 0) begin first_re = k; first_ra = ra0; end
            if (fs0 && first_fs < 0) first_fs = k;
        end
        total++; if (first_re != 1 || first_ra !== '0) begin bad++; $display("FAIL restart_addr got=%0d@%0d exp=0@1", first_ra, first_re); end
        total++; if (first_fs != 3) begin bad++; $display("FAIL restart_fs got=%0d exp=3", first_fs); end
    endtask

    task automatic test_toggle();
        int ph, start = 0, fs_in = 0, intervals = 0;
        logic prev_bz = 1'b0;
        rst_n = 1'b0; enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ph = int'($urandom_range(0, 9));
        for (int k = 0; k < 4 * FRAME + 20; k++) begin
            enable = (k < 3 * FRAME) && (k % 10 == ph);
            @(negedge clk);
            total++; if (obs0 !== exp0) begin bad++; $display("FAIL toggle cyc=%0d got=%h exp=%h", cyc, obs0, exp0); end
            if (fs0) fs_in++;
            if (bz0 && !prev_bz) begin start = k; fs_in = 0; end
            if (!bz0 && prev_bz) begin
                intervals++;
                total++;
                if ((k - start) % FRAME != 0 || fs_in != (k - start) / FRAME) begin
                    bad++; $display("FAIL toggle_frame len=%0d fs=%0d", k - start, fs_in);
                end
            end
            prev_bz = bz0;
        end
        enable = 1'b0;
        total++; if (intervals < 1 || bz0 !== 1'b0) begin bad++; $display("FAIL toggle_end got=%0d,%b exp>=1,0", intervals, bz0); end
    endtask

    initial begin
        fill_mem(1'b0);
        test_reset();
        test_first_frame();
        test_line_frame();
        test_invert();
        test_drain();
        fill_mem(1'b1);
        test_reset_midline();
        test_toggle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_se_video_scanner.md
Name: mac_se_video_scanner

Overview:
- Read-side client of the frame_buffer.
- Scans the 512x342 1-bit image in raster order on the read port and generates Mac SE internal-CRT timing: video_out, hsync_n and vsync_n.
- Runs in the pixel clock domain (nominally 15.6672 MHz) and is the output end of the HDMI-to-Mac-SE path.
- The frame_buffer write side is fed by the scaler in the HDMI clock domain.

Parameters:
- BUFFER_WIDTH, 512, active pixels per line.
- BUFFER_HEIGHT, 342, active lines per frame.
- ADDR_WIDTH, 18, frame_buffer address width.
- H_TOTAL, 704, pixel clocks per line.
- V_TOTAL, 370, lines per frame.
- HS_START, 528, h_count at which hsync_n goes low.
- HS_END, 704, h_count (exclusive) at which hsync_n returns high.
- VS_START, 342, v_count at which vsync_n goes low.
- VS_END, 346, v_count (exclusive) at which vsync_n returns high.
- INVERT, 0, when 1 video_out = ~pixel.

Ports:
- read_clk  in  1  pixel clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  request scanning; sampled only at frame boundaries (see Behaviour).
- read_enable  out  1  frame_buffer read strobe.
- read_addr  out  ADDR_WIDTH  frame_buffer read address.
- read_data  in  1  frame_buffer data, valid 1 cycle after read_enable/read_addr.
- video_out  out  1  serial pixel; 1 = black (Mac convention, before INVERT); 0 during blanking.
- hsync_n  out  1  horizontal sync, active low.
- vsync_n  out  1  vertical sync, active low.
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0) on video_out.
- busy  out  1  high in RUN or DRAIN.

Behaviour:
Reset values:
- reset_n low asynchronously forces state IDLE and h_count = v_count = addr_ctr = 0.
- read_enable = 0, read_addr = 0, video_out = 0, hsync_n = 1, vsync_n = 1, frame_start = 0, busy = 0.
- This applies at any time, including mid-line or mid-frame. No partial-frame recovery: after release, scanning restarts from (0,0).

State machine:
- IDLE:
  - Counters held at 0; outputs at reset values.
  - enable = 1 -> RUN; the first cycle of RUN has h = 0, v = 0.
- RUN:
  - h_count increments 0..H_TOTAL-1 and wraps to 0.
  - On wrap, v_count increments 0..V_TOTAL-1 and wraps to 0.
  - enable = 0 sampled in any cycle -> DRAIN (the frame in progress continues unchanged).
- DRAIN:
  - Identical to RUN.
  - At the frame wrap (h = H_TOTAL-1, v = V_TOTAL-1): enable = 1 -> RUN; enable = 0 -> IDLE.
  - enable re-asserting mid-DRAIN does not cut the frame short; the frame always completes.
- RUN at the frame wrap continues into the next frame with no gap cycle.

Address generation:
- active = (h_count < BUFFER_WIDTH) && (v_count < BUFFER_HEIGHT).
- addr_ctr increments by 1 on each active cycle and is cleared to 0 at the frame wrap. No multiplier is used.
- Line v therefore starts at address v*512; the last pixel is 175103.
- read_enable and read_addr are registered outputs: they present counter position (h, v) one cycle after the counters hold it.
- read_enable = active; read_addr = addr_ctr when active, otherwise it holds its last value.

Pipeline alignment:
- Counter cycle N -> read_addr at N+1 -> read_data at N+2 -> video_out registered at N+3.
- video_out = active_d3 ? (read_data ^ INVERT) : 0.
- hsync_n = ~(HS_START <= h < HS_END), delayed to N+3.
- vsync_n = ~(VS_START <= v < VS_END), delayed to N+3. It changes only on line boundaries (h = 0 of the delayed stream).
- frame_start = (h = 0 && v = 0 && state != IDLE), delayed to N+3.
- The delay lines flush on return to IDLE. The last 3 cycles of DRAIN output complete normally before the outputs settle to reset values.

Timing arithmetic:
- Line = 704 clocks; hsync_n low 176 clocks per line.
- Frame = 370 lines = 260480 clocks; vsync_n low 4 lines = 2816 clocks.
- 15.6672 MHz gives 22.25 kHz line rate and 60.15 Hz frame rate.
- Counter widths are $clog2(H_TOTAL) and $clog2(V_TOTAL). Parameters must satisfy H_TOTAL > BUFFER_WIDTH and V_TOTAL > BUFFER_HEIGHT. HS_END may equal H_TOTAL.

Test Plan:
1. Reset, enable = 1, behavioural RAM with data = addr[0]:
   - read_enable first high with read_addr = 0.
   - frame_start pulses 3 cycles after IDLE->RUN.
   - video_out = 0,1,0,1... for 512 cycles, then 0 for 192 cycles.
2. Line/frame counting:
   - read_addr = 512 at the first active cycle of line 1; 175103 is the last address; it returns to 0 after 260480 cycles.
   - hsync_n low exactly 176 of every 704 clocks, starting 528 clocks after each line's pixel 0.
   - vsync_n low exactly 2816 clocks starting at line 342; frame_start period = 260480.
3. INVERT = 1, RAM all zeros:
   - video_out = 1 on all 512x342 active pixels, 0 in blanking.
   - Sync timing identical to scenario 2.
4. enable dropped at line 100, raised again at line 200:
   - Frame completes with busy = 1 and continues into the next frame (RUN).
   - Repeat without re-raising: after the frame wrap plus 3 cycles, busy = 0, syncs high, read_enable = 0.
5. reset_n pulsed low mid-line (h = 300, v = 50) with enable held 1:
   - All outputs reach reset values in the same cycle.
   - After release, the first read_addr = 0 and frame_start fires 3 cycles after RUN entry.
6. enable toggled 1-cycle high/low every 10 cycles starting in IDLE:
   - A single entry to RUN occurs; each started frame always completes in full (260480 cycles).
   - No frame_start pulse occurs outside a frame boundary.
